alu_mc_param: RTL and testbench

//   Parametrised multi-cycle ALU with a valid/ready handshake on both sides. It is the

---
 rtl/alu_mc_pkg.sv | 42 ++++
 rtl/alu_mc_iter.sv | 77 +++++++
 rtl/alu_mc_param.sv | 168 ++++++++++++++++
 tb/tb_alu_mc_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_pkg
// Brief    : Opcodes, FSM state type and opcode helpers for alu_mc_param.
// Revision : 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_MUL  = 4'd2;
  localparam logic [3:0] ALU_OP_MULH = 4'd3;
  localparam logic [3:0] ALU_OP_DIV  = 4'd4;
  localparam logic [3:0] ALU_OP_REM  = 4'd5;
  localparam logic [3:0] ALU_OP_SLT  = 4'd6;
  localparam logic [3:0] ALU_OP_SLTU = 4'd7;
  localparam logic [3:0] ALU_OP_SLL  = 4'd8;
  localparam logic [3:0] ALU_OP_SRL  = 4'd9;
  localparam logic [3:0] ALU_OP_SRA  = 4'd10;
  localparam logic [3:0] ALU_OP_AND  = 4'd11;
  localparam logic [3:0] ALU_OP_OR   = 4'd12;
  localparam logic [3:0] ALU_OP_XOR  = 4'd13;
  localparam logic [3:0] ALU_OP_NOT  = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_MULH) ||
           (op == ALU_OP_DIV) || (op == ALU_OP_REM);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_OP_DIV) || (op == ALU_OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_iter
// Brief    : Shared one-bit-per-cycle shift-add multiplier / restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         busy,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  logic         r_mode;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_opd;
  logic [W:0]   w_shift;
  logic [W+1:0] w_lhs;
  logic [W+1:0] w_rhs;
  logic [W+1:0] w_sum;

  assign w_shift = {r_hi, r_lo[W-1]};

  // One adder serves both modes: add multiplicand, or subtract divisor.
  always_comb begin
    if (r_mode) begin
      w_lhs = {1'b0, w_shift};
      w_rhs = ~{2'b00, r_opd};
    end else begin
      w_lhs = {2'b00, r_hi};
      w_rhs = r_lo[0] ? {2'b00, r_opd} : '0;
    end
  end

  assign w_sum = w_lhs + w_rhs + {{(W+1){1'b0}}, r_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opd  <= '0;
    end else if (start) begin
      r_mode <= mode;
      r_hi   <= '0;
      r_opd  <= mode ? b : a;
      r_lo   <= mode ? a : b;
    end else if (busy) begin
      if (r_mode) begin
        // Negative difference means the divisor did not fit: restore.
        if (w_sum[W+1]) begin
          r_hi <= w_shift[W-1:0];
          r_lo <= {r_lo[W-2:0], 1'b0};
        end else begin
          r_hi <= w_sum[W-1:0];
          r_lo <= {r_lo[W-2:0], 1'b1};
        end
      end else begin
        r_hi <= w_sum[W:1];
        r_lo <= {w_sum[0], r_lo[W-1:1]};
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/alu_mc_param.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_param
// Brief    : Multi-cycle ALU with valid/ready on both sides. MUL/MULH/DIV/REM
//            are built only when ALU_MC_MULDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc_param
  import alu_mc_pkg::*;
#(
  parameter  int W   = 32,
  localparam int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         err
);

  alu_state_t     r_state;
  logic           w_accept;
  logic [SHW-1:0] w_shamt;
  logic [W-1:0]   w_simple_res;
  logic           w_simple_err;

  assign in_ready = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept = in_valid && in_ready;
  assign w_shamt  = op2[SHW-1:0];

  always_comb begin
    w_simple_res = '0;
    w_simple_err = 1'b0;
    case (op)
      ALU_OP_ADD:  w_simple_res = op1 + op2;
      ALU_OP_SUB:  w_simple_res = op1 - op2;
      ALU_OP_SLT:  w_simple_res[0] = $signed(op1) < $signed(op2);
      ALU_OP_SLTU: w_simple_res[0] = op1 < op2;
      ALU_OP_SLL:  w_simple_res = op1 << w_shamt;
      ALU_OP_SRL:  w_simple_res = op1 >> w_shamt;
      ALU_OP_SRA:  w_simple_res = $signed(op1) >>> w_shamt;
      ALU_OP_AND:  w_simple_res = op1 & op2;
      ALU_OP_OR:   w_simple_res = op1 | op2;
      ALU_OP_XOR:  w_simple_res = op1 ^ op2;
      ALU_OP_NOT:  w_simple_res = ~op1;
`ifdef ALU_MC_MULDIV_EN
      // Only the divide-by-zero early-out takes this path for DIV/REM.
      ALU_OP_DIV:  w_simple_res = '1;
      ALU_OP_REM:  w_simple_res = op1;
      ALU_OP_MUL,
      ALU_OP_MULH: w_simple_res = '0;
`endif
      default:     w_simple_err = 1'b1;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  localparam logic [SHW-1:0] c_cnt_last = SHW'(W - 1);

  logic [SHW-1:0] r_cnt;
  logic [3:0]     r_op;
  logic           r_neg;
  logic           w_mode;
  logic           w_go_iter;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [W-1:0]   w_hi;
  logic [W-1:0]   w_lo;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_s;
  logic [W-1:0]   w_fix_res;

  function automatic logic [W-1:0] f_mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

  assign w_mode    = is_div_op(op);
  assign w_go_iter = is_iter_op(op) && !(w_mode && (op2 == '0));
  // Most-negative magnitude is 2^(W-1), which still fits unsigned in W bits.
  assign w_a       = w_mode ? op1 : f_mag(op1);
  assign w_b       = w_mode ? op2 : f_mag(op2);
  assign w_prod    = {w_hi, w_lo};
  assign w_prod_s  = r_neg ? (~w_prod + 1'b1) : w_prod;

  always_comb begin
    case (r_op)
      ALU_OP_MUL:  w_fix_res = w_prod_s[W-1:0];
      ALU_OP_MULH: w_fix_res = w_prod_s[2*W-1:W];
      ALU_OP_DIV:  w_fix_res = w_lo;
      default:     w_fix_res = w_hi;
    endcase
  end

  alu_mc_iter #(
    .W (W)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (w_accept && w_go_iter),
    .mode  (w_mode),
    .a     (w_a),
    .b     (w_b),
    .busy  (r_state == ITER),
    .hi    (w_hi),
    .lo    (w_lo)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      res       <= '0;
      err       <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
      r_cnt     <= '0;
      r_op      <= ALU_OP_ADD;
      r_neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
`ifdef ALU_MC_MULDIV_EN
            if (w_go_iter) begin
              r_state   <= ITER;
              out_valid <= 1'b0;
              r_cnt     <= '0;
              r_op      <= op;
              r_neg     <= !w_mode && (op1[W-1] ^ op2[W-1]);
            end else
`endif
            begin
              r_state   <= DONE;
              out_valid <= 1'b1;
              res       <= w_simple_res;
              err       <= w_simple_err;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MC_MULDIV_EN
        ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_last) r_state <= FIX;
        end
        FIX: begin
          r_state   <= DONE;
          out_valid <= 1'b1;
          res       <= w_fix_res;
          err       <= 1'b0;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc_param
// Brief    : Directed plus randomized self-checking bench for alu_mc_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc_param;

  localparam int W = 32;
`ifdef ALU_MC_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op        = 4'd0;
  logic [W-1:0] op1       = '0;
  logic [W-1:0] op2       = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] res;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  alu_mc_param #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: {err, res} straight from the arithmetic definitions.
  function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       p;
    logic [W-1:0] t;
    p = longint'($signed(a)) * longint'($signed(b));
    case (o)
      4'd0:  return {1'b0, a + b};
      4'd1:  return {1'b0, a - b};
      4'd2:  return MULDIV ? {1'b0, p[31:0]}  : {1'b1, 32'd0};
      4'd3:  return MULDIV ? {1'b0, p[63:32]} : {1'b1, 32'd0};
      4'd4:  return MULDIV ? {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b} : {1'b1, 32'd0};
      4'd5:  return MULDIV ? {1'b0, (b == 0) ? a : a % b} : {1'b1, 32'd0};
      4'd6:  return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      4'd7:  return {1'b0, 31'd0, (a < b)};
      4'd8:  return {1'b0, a << b[4:0]};
      4'd9:  return {1'b0, a >> b[4:0]};
      4'd10: begin t = $signed(a) >>> b[4:0]; return {1'b0, t}; end
      4'd11: return {1'b0, a & b};
      4'd12: return {1'b0, a | b};
      4'd13: return {1'b0, a ^ b};
      4'd14: return {1'b0, ~a};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [W-1:0] b);
    if (MULDIV && (o == 4'd2 || o == 4'd3 || ((o == 4'd4 || o == 4'd5) && b != 0)))
      return W + 1;
    return 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  // Caller is at a negedge; returns at the negedge where the result shows.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic exp_err, input string tag);
    int g, lat, early;
    g = 0;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 0; early = 0;
    do begin
      @(negedge clk); lat++;
      if (!out_valid && in_ready) early++;
    end while (!out_valid && lat < 100);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'(ref_lat(o, b)));
    check({tag, "_busy_rdy"}, 32'(early), 32'd0);
  endtask

  task automatic run_rand(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W:0] e;
    e = model(o, a, b);
    run_op(o, a, b, e[W-1:0], e[W], tag);
  endtask

  initial begin
    logic [3:0]   bo [3];
    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    logic [W-1:0] be [3];
    logic [W-1:0] held;
    int           seen;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(in_ready), 32'd1);

    // Simple ops
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "add_wrap");
    run_op(4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, "sub");
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "slt");
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "sltu");
    run_op(4'd14, 32'h1234_5678, 32'd0, 32'hEDCB_A987, 1'b0, "not");

    // Multi-cycle ops and their edge cases
    run_op(4'd2, 32'hFFFF_FFF9, 32'd3, MULDIV ? 32'hFFFF_FFEB : 32'd0, !MULDIV, "mul");
    run_op(4'd3, 32'hFFFF_FFF9, 32'd3, MULDIV ? 32'hFFFF_FFFF : 32'd0, !MULDIV, "mulh");
    run_op(4'd3, 32'h8000_0000, 32'h8000_0000, MULDIV ? 32'h4000_0000 : 32'd0, !MULDIV, "mulh_minneg");
    run_op(4'd2, 32'h8000_0000, 32'h8000_0000, 32'd0, !MULDIV, "mul_minneg");
    run_op(4'd4, 32'd100, 32'd7, MULDIV ? 32'd14 : 32'd0, !MULDIV, "div");
    run_op(4'd5, 32'd100, 32'd7, MULDIV ? 32'd2 : 32'd0, !MULDIV, "rem");
    run_op(4'd4, 32'd5, 32'd0, MULDIV ? 32'hFFFF_FFFF : 32'd0, !MULDIV, "div0");
    run_op(4'd5, 32'd5, 32'd0, MULDIV ? 32'd5 : 32'd0, !MULDIV, "rem0");

    // Back-to-back issue: one result per cycle
    in_valid = 1'b0; @(negedge clk);
    bo = '{4'd13, 4'd10, 4'd8};
    ba = '{32'hF0F0_F0F0, 32'h8000_0000, 32'd1};
    bb = '{32'h0FF0_0FF0, 32'd4, 32'd33};
    be = '{32'hFF00_FF00, 32'hF800_0000, 32'h0000_0002};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = bo[i]; op1 = ba[i]; op2 = bb[i];
      @(negedge clk);
      check($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("b2b%0d_res", i), res, be[i]);
      check($sformatf("b2b%0d_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure: result held, further input refused
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd0; op1 = 32'd10; op2 = 32'd20;
    @(posedge clk); #1;
    op = 4'd1; op1 = $urandom; op2 = $urandom;
    held = 32'd30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_res", i), res, held);
      check($sformatf("bp%0d_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(out_valid), 32'd0);
    run_op(4'd15, 32'd7, 32'd9, 32'd0, 1'b1, "illegal");

    // Reset in the middle of a DIV
    in_valid = 1'b1; op = 4'd4; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_res", res, 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    run_op(4'd0, 32'd1, 32'd1, 32'd2, 1'b0, "add_after_rst");

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      run_rand(4'($urandom_range(0, 15)), pick(), pick(), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
